// File: rtl/dbus_peri_ctrl.sv
// Peripheral data-bus initiator: one outstanding core load/store, slot decode, ack/err return.
// Optional access watchdog enabled by defining DBUS_TIMEOUT_EN.
module dbus_peri_ctrl #(
  parameter int unsigned NUM_PERI       = 5,
  parameter int unsigned REGION_BITS    = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h9000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lsu_req_i,
  input  logic                   lsu_we_i,
  input  logic [31:0]            lsu_addr_i,
  input  logic [31:0]            lsu_wdata_i,
  input  logic [3:0]             lsu_be_i,
  output logic                   lsu_ack_o,
  output logic                   lsu_err_o,
  output logic [31:0]            lsu_rdata_o,
  output logic                   lsu_busy_o,
  output logic [NUM_PERI-1:0]    peri_sel_o,
  output logic                   peri_req_o,
  output logic                   peri_we_o,
  output logic [REGION_BITS-1:0] peri_addr_o,
  output logic [31:0]            peri_wdata_o,
  output logic [3:0]             peri_be_o,
  input  logic                   peri_ack_i,
  input  logic [31:0]            peri_rdata_i
);

  localparam int unsigned IDX_W   = (NUM_PERI > 2) ? $clog2(NUM_PERI) : 1;
  localparam int unsigned TAG_LSB = REGION_BITS + IDX_W;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
  state_t state_reg, state_next;

  logic [IDX_W-1:0]       req_idx;
  logic                   hit;
  logic [IDX_W-1:0]       idx_reg;
  logic                   we_reg;
  logic [REGION_BITS-1:0] addr_reg;
  logic [31:0]            wdata_reg;
  logic [3:0]             be_reg;
  logic [31:0]            rdata_reg;
  logic                   timeout;

  assign req_idx = lsu_addr_i[REGION_BITS +: IDX_W];
  assign hit     = (lsu_addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) &&
                   (32'(req_idx) < NUM_PERI);

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_reg;

  assign timeout = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts ACCESS cycles; restarts on every entry into ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (state_reg == IDLE && state_next == ACCESS) begin
      cnt_reg <= '0;
    end else if (state_reg == ACCESS) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // An ack arriving on the terminal count takes priority over the timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (lsu_req_i) state_next = hit ? ACCESS : ERR;
      ACCESS: begin
        if (peri_ack_i)   state_next = RESP;
        else if (timeout) state_next = ERR;
      end
      RESP:     state_next = IDLE;
      ERR:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      rdata_reg <= '0;
    end else begin
      if (state_reg == IDLE && lsu_req_i) begin
        idx_reg   <= req_idx;
        we_reg    <= lsu_we_i;
        addr_reg  <= lsu_addr_i[REGION_BITS-1:0];
        wdata_reg <= lsu_wdata_i;
        be_reg    <= lsu_be_i;
        if (!hit) rdata_reg <= '0;
      end
      // Error responses return zero data; writes never capture responder data.
      if (state_reg == ACCESS) begin
        if (peri_ack_i)   rdata_reg <= we_reg ? 32'h0 : peri_rdata_i;
        else if (timeout) rdata_reg <= '0;
      end
    end
  end

  assign lsu_ack_o    = (state_reg == RESP) || (state_reg == ERR);
  assign lsu_err_o    = (state_reg == ERR);
  assign lsu_busy_o   = (state_reg != IDLE);
  assign lsu_rdata_o  = rdata_reg;
  assign peri_req_o   = (state_reg == ACCESS);
  assign peri_we_o    = we_reg;
  assign peri_addr_o  = addr_reg;
  assign peri_wdata_o = wdata_reg;
  assign peri_be_o    = be_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PERI; gi++) begin : g_sel
      assign peri_sel_o[gi] = peri_req_o && (idx_reg == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_dbus_peri_ctrl.sv
// Self-checking bench for dbus_peri_ctrl: transaction-level model plus directed scenarios.
// Timeout scenarios run only when DBUS_TIMEOUT_EN is defined.
module tb_dbus_peri_ctrl;

  localparam int          NUM_PERI = 5;
  localparam int          TO       = 256;
  localparam logic [31:0] BASE     = 32'h9000_0000;
`ifdef DBUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        lsu_req_i = 1'b0, lsu_we_i = 1'b0;
  logic [31:0] lsu_addr_i = '0, lsu_wdata_i = '0;
  logic [3:0]  lsu_be_i = '0;
  logic        lsu_ack_o, lsu_err_o, lsu_busy_o;
  logic [31:0] lsu_rdata_o;
  logic [4:0]  peri_sel_o;
  logic        peri_req_o, peri_we_o;
  logic [7:0]  peri_addr_o;
  logic [31:0] peri_wdata_o;
  logic [3:0]  peri_be_o;
  logic        peri_ack_i = 1'b0;
  logic [31:0] peri_rdata_i = '0;

  dbus_peri_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_be_i(lsu_be_i),
    .lsu_ack_o(lsu_ack_o), .lsu_err_o(lsu_err_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_busy_o(lsu_busy_o), .peri_sel_o(peri_sel_o), .peri_req_o(peri_req_o),
    .peri_we_o(peri_we_o), .peri_addr_o(peri_addr_o), .peri_wdata_o(peri_wdata_o),
    .peri_be_o(peri_be_o), .peri_ack_i(peri_ack_i), .peri_rdata_i(peri_rdata_i)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  int edge_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  // Responder script and scenario knobs shared by driver, responder and model
  int          cur_wait = 0;
  logic [31:0] cur_resp = '0;
  bit          spurious = 1'b0;

  // Transaction model: decides from the address range and latency rules when
  // each output event must happen, counted in clock edges.
  int          next_accept = 0;
  bit          m_active = 1'b0, m_hit = 1'b0, m_we = 1'b0, m_tmo = 1'b0;
  int          m_n = 0, m_last_acc = 0, m_tack = 0;
  logic [4:0]  m_sel = '0;
  logic [7:0]  m_off = '0;
  logic [31:0] m_wdata = '0, m_rdata = '0, last_rdata = '0;
  logic [3:0]  m_be = '0;
  longint      off_l;

  always @(posedge clk) begin
    edge_cnt++;
    if (!rst_n) begin
      next_accept = edge_cnt + 1;
    end else if (lsu_req_i && edge_cnt >= next_accept) begin
      off_l    = longint'(lsu_addr_i) - longint'(BASE);
      m_active = 1'b1;
      m_n      = edge_cnt;
      m_we     = lsu_we_i;
      m_wdata  = lsu_wdata_i;
      m_be     = lsu_be_i;
      m_off    = lsu_addr_i[7:0];
      m_hit    = (off_l >= 0) && (off_l < NUM_PERI * 256);
      m_sel    = m_hit ? 5'(1 << (off_l / 256)) : 5'b0;
      if (!m_hit) begin
        m_tmo      = 1'b0;
        m_last_acc = edge_cnt - 1;
        m_tack     = edge_cnt;
        m_rdata    = '0;
      end else begin
        m_tmo      = TMO_EN && (cur_wait >= TO);
        m_last_acc = edge_cnt + (m_tmo ? TO - 1 : cur_wait);
        m_tack     = m_last_acc + 1;
        m_rdata    = (m_tmo || lsu_we_i) ? 32'h0 : cur_resp;
      end
      next_accept = m_tack + 2;
    end
  end

  always @(negedge rst_n) begin
    m_active   = 1'b0;
    last_rdata = '0;
  end

  // Responder: acks after cur_wait wait cycles, optionally acks spuriously while idle
  int acc_cnt = 0;
  always @(negedge clk) begin
    peri_ack_i   = 1'b0;
    peri_rdata_i = '0;
    if (peri_req_o) begin
      if (acc_cnt == cur_wait) begin
        peri_ack_i   = 1'b1;
        peri_rdata_i = cur_resp;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      if (spurious) begin
        peri_ack_i   = 1'b1;
        peri_rdata_i = 32'hDEAD_BEEF;
      end
    end
  end

  // Compare process plus observation capture for the directed literal checks
  bit          in_acc, ack_e, busy_e;
  logic [4:0]  obs_sel = '0;
  logic [7:0]  obs_addr = '0;
  int          obs_acc = 0, obs_ack_e = 0;
  logic        obs_err = 1'b0;
  logic [31:0] obs_rdata = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ack",   32'(lsu_ack_o),   32'h0);
      check("rst_err",   32'(lsu_err_o),   32'h0);
      check("rst_busy",  32'(lsu_busy_o),  32'h0);
      check("rst_rdata", lsu_rdata_o,      32'h0);
      check("rst_req",   32'(peri_req_o),  32'h0);
      check("rst_sel",   32'(peri_sel_o),  32'h0);
      check("rst_pay",   32'(peri_we_o) | 32'(peri_addr_o) | peri_wdata_o | 32'(peri_be_o), 32'h0);
    end else begin
      in_acc = m_active && m_hit && edge_cnt >= m_n && edge_cnt <= m_last_acc;
      ack_e  = m_active && edge_cnt == m_tack;
      busy_e = m_active && edge_cnt >= m_n && edge_cnt <= m_tack;
      check("lsu_ack",   32'(lsu_ack_o),  32'(ack_e));
      check("lsu_err",   32'(lsu_err_o),  32'(ack_e && (!m_hit || m_tmo)));
      check("lsu_busy",  32'(lsu_busy_o), 32'(busy_e));
      check("peri_req",  32'(peri_req_o), 32'(in_acc));
      check("peri_sel",  32'(peri_sel_o), in_acc ? 32'(m_sel) : 32'h0);
      check("lsu_rdata", lsu_rdata_o,     ack_e ? m_rdata : last_rdata);
      if (ack_e) last_rdata = m_rdata;
      if (in_acc) begin
        check("peri_addr",  32'(peri_addr_o), 32'(m_off));
        check("peri_we",    32'(peri_we_o),   32'(m_we));
        check("peri_wdata", peri_wdata_o,     m_wdata);
        check("peri_be",    32'(peri_be_o),   32'(m_be));
      end
      if (peri_req_o) begin
        obs_sel  = obs_sel | peri_sel_o;
        obs_addr = peri_addr_o;
        obs_acc++;
      end
      if (lsu_ack_o) begin
        obs_ack_e = edge_cnt;
        obs_err   = lsu_err_o;
        obs_rdata = lsu_rdata_o;
      end
    end
  end

  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int wait_n, input logic [31:0] resp,
                         input bit chain, output int lat);
    int e0, n;
    @(negedge clk); #1;
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_addr_i = addr; lsu_wdata_i = wdata; lsu_be_i = be;
    cur_wait = wait_n; cur_resp = resp;
    obs_sel = '0; obs_addr = '0; obs_acc = 0; obs_err = 1'b0; obs_rdata = '0;
    e0 = edge_cnt;
    n  = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!lsu_ack_o && n < 400);
    if (!lsu_ack_o) check("ack_wait_expired", 32'(lsu_ack_o), 32'h1);
    lat = edge_cnt - e0;
    if (!chain) lsu_req_i = 1'b0;
    $display("txn we=%0d addr=%08h lat=%0d err=%0d rdata=%08h sel=%05b acc=%0d",
             we, addr, lat, obs_err, obs_rdata, obs_sel, obs_acc);
  endtask

  int lat, lat2, a1;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("reset_busy_literal", 32'(lsu_busy_o), 32'h0);
    rst_n = 1'b1;

    // Read slot 0, immediate ack
    run_txn(1'b0, 32'h9000_0004, 32'h0, 4'hF, 0, 32'hA5A5_0001, 1'b0, lat);
    check("rd0_lat",   32'(lat),       32'd2);
    check("rd0_sel",   32'(obs_sel),   32'h01);
    check("rd0_addr",  32'(obs_addr),  32'h04);
    check("rd0_rdata", obs_rdata,      32'hA5A5_0001);
    check("rd0_err",   32'(obs_err),   32'h0);

    // Miss: index beyond the last slot
    run_txn(1'b0, 32'h9000_0500, 32'h0, 4'hF, 0, 32'h5555_5555, 1'b0, lat);
    check("miss5_lat",   32'(lat),     32'd1);
    check("miss5_err",   32'(obs_err), 32'h1);
    check("miss5_rdata", obs_rdata,    32'h0);
    check("miss5_acc",   32'(obs_acc), 32'h0);

    // Write slot 3 with three wait cycles; responder data must not be captured
    run_txn(1'b1, 32'h9000_0310, 32'h0000_00FF, 4'b0001, 3, 32'h1234_5678, 1'b0, lat);
    check("wr3_lat",   32'(lat),      32'd5);
    check("wr3_sel",   32'(obs_sel),  32'h08);
    check("wr3_acc",   32'(obs_acc),  32'd4);
    check("wr3_addr",  32'(obs_addr), 32'h10);
    check("wr3_rdata", obs_rdata,     32'h0);
    check("wr3_err",   32'(obs_err),  32'h0);

    // Miss: outside the peripheral window entirely
    run_txn(1'b0, 32'h8000_0000, 32'h0, 4'hF, 0, 32'h7777_7777, 1'b0, lat);
    check("miss8_lat", 32'(lat),     32'd1);
    check("miss8_err", 32'(obs_err), 32'h1);
    check("miss8_acc", 32'(obs_acc), 32'h0);

    // Spurious acks while idle are ignored
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    #1 spurious = 1'b0;
    check("spur_rdata_hold", lsu_rdata_o, 32'h0);

    // Back-to-back reads with lsu_req_i held high
    run_txn(1'b0, 32'h9000_0120, 32'h0, 4'hF, 0, 32'h1111_1111, 1'b1, lat);
    a1 = obs_ack_e;
    check("b2b1_rdata", obs_rdata,    32'h1111_1111);
    check("b2b1_sel",   32'(obs_sel), 32'h02);
    run_txn(1'b0, 32'h9000_0208, 32'h0, 4'hF, 1, 32'h2222_2222, 1'b0, lat2);
    check("b2b2_rdata", obs_rdata,    32'h2222_2222);
    check("b2b2_sel",   32'(obs_sel), 32'h04);
    check("b2b2_lat",   32'(lat2),    32'd3);
    check("b2b_gap",    32'(obs_ack_e - a1), 32'd4);

    // Reset in the middle of an access
    @(negedge clk); #1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h9000_0400; lsu_be_i = 4'hF;
    cur_wait = 10; cur_resp = 32'hBAD0_0004;
    repeat (3) @(negedge clk);
    #1 check("mid_req_before_rst", 32'(peri_req_o), 32'h1);
    #1 rst_n = 1'b0;
    #1 check("mid_rst_req",  32'(peri_req_o), 32'h0);
    check("mid_rst_sel",  32'(peri_sel_o), 32'h0);
    check("mid_rst_busy", 32'(lsu_busy_o), 32'h0);
    lsu_req_i = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run_txn(1'b0, 32'h9000_0200, 32'h0, 4'hF, 1, 32'hCAFE_0002, 1'b0, lat);
    check("post_rst_lat",   32'(lat),  32'd3);
    check("post_rst_rdata", obs_rdata, 32'hCAFE_0002);

`ifdef DBUS_TIMEOUT_EN
    run_txn(1'b0, 32'h9000_0100, 32'h0, 4'hF, 1000, 32'h3333_3333, 1'b0, lat);
    check("tmo_lat",   32'(lat),     32'd257);
    check("tmo_err",   32'(obs_err), 32'h1);
    check("tmo_acc",   32'(obs_acc), 32'd256);
    check("tmo_rdata", obs_rdata,    32'h0);
    run_txn(1'b0, 32'h9000_0100, 32'h0, 4'hF, 255, 32'h4444_4444, 1'b0, lat);
    check("tmo_edge_lat",   32'(lat),     32'd257);
    check("tmo_edge_err",   32'(obs_err), 32'h0);
    check("tmo_edge_rdata", obs_rdata,    32'h4444_4444);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
